// File: rtl/beagleg_pkg.sv
// Shared motion types for the step-generation pipeline.
package beagleg_pkg;

  typedef struct packed {
    logic [15:0] v0;
    logic [15:0] v1;
    logic [3:0]  direction;
    logic [31:0] target_steps;
  } motion_segment_t;

  localparam int MOTION_SEGMENT_W   = $bits(motion_segment_t);
  localparam int SEGMENT_FIFO_DEPTH = 16;

endpackage

// File: rtl/motion_segment_fifo.sv
// Show-ahead segment FIFO feeding segment_step_generator.
// Zero-step segments are accepted but discarded and counted.
// Fill level and a sticky underflow flag are reported.
module motion_segment_fifo
  import beagleg_pkg::*;
#(
  parameter int DEPTH      = SEGMENT_FIFO_DEPTH,
  parameter int DROP_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  motion_segment_t             wr_data,
  output logic                        data_available,
  input  logic                        data_request,
  output motion_segment_t             data,
  output logic [$clog2(DEPTH):0]      level,
  output logic [DROP_CNT_W-1:0]       drop_count,
  output logic                        underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [MOTION_SEGMENT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [LW-1:0]               r_level;
  logic [DROP_CNT_W-1:0]       r_drop_cnt;
  logic                        r_underflow;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_zero_steps;
  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_underflow;

  // Status flags derive only from the registered level, so wr_ready has
  // no combinational dependency on data_request.
  assign w_full       = (r_level == LW'(DEPTH));
  assign w_empty      = (r_level == '0);
  assign w_accept     = wr_valid & ~w_full;
  assign w_zero_steps = (wr_data.target_steps == '0);

  // A flush cycle swallows any concurrent traffic, including its side effects.
  assign w_push       = w_accept & ~w_zero_steps & ~flush;
  assign w_drop       = w_accept &  w_zero_steps & ~flush;
  assign w_pop        = data_request & ~w_empty & ~flush;
  assign w_underflow  = data_request &  w_empty & ~flush;

  assign wr_ready       = ~w_full;
  assign data_available = ~w_empty;
  assign data           = motion_segment_t'(r_mem[r_rd_ptr]);
  assign level          = r_level;
  assign drop_count     = r_drop_cnt;
  assign underflow_err  = r_underflow;

  // Storage array write; contents are never cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointer, level, drop counter and sticky underflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_drop_cnt  <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push && !w_pop) begin
          r_level <= r_level + LW'(1);
        end else if (w_pop && !w_push) begin
          r_level <= r_level - LW'(1);
        end
      end
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_motion_segment_fifo.sv
// Directed and randomized bench for motion_segment_fifo with a queue model.
module tb_motion_segment_fifo;
  import beagleg_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = 5;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int DMAX  = (1 << DW) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  wr_valid = 1'b0;
  logic                  wr_ready;
  motion_segment_t       wr_data = '0;
  logic                  data_available;
  logic                  data_request = 1'b0;
  motion_segment_t       data;
  logic [LW-1:0]         level;
  logic [DW-1:0]         drop_count;
  logic                  underflow_err;

  int checks = 0;
  int failures = 0;

  motion_segment_t m_q[$];
  int              m_drop = 0;
  bit              m_und = 1'b0;

  always #5 clk = ~clk;

  motion_segment_fifo #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .data_available(data_available), .data_request(data_request), .data(data),
    .level(level), .drop_count(drop_count), .underflow_err(underflow_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic motion_segment_t mkseg(input int unsigned ts);
    motion_segment_t s;
    s.v0           = 16'($urandom);
    s.v1           = 16'($urandom);
    s.direction    = 4'($urandom);
    s.target_steps = ts;
    return s;
  endfunction

  task automatic check_all();
    chk("wr_ready", 128'(wr_ready), 128'(m_q.size() < DEPTH));
    chk("data_available", 128'(data_available), 128'(m_q.size() != 0));
    chk("level", 128'(level), 128'(m_q.size()));
    chk("drop_count", 128'(drop_count), 128'(m_drop));
    chk("underflow_err", 128'(underflow_err), 128'(m_und));
    if (m_q.size() != 0) chk("head_data", 128'(data), 128'(m_q[0]));
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, then check.
  task automatic cyc(input bit v, input motion_segment_t d, input bit req,
                     input bit fl, input bit r);
    bit acc;
    bit popok;
    wr_valid = v; wr_data = d; data_request = req; flush = fl; rst = r;
    acc   = v && (m_q.size() < DEPTH);
    popok = req && (m_q.size() > 0);
    @(posedge clk);
    if (r) begin
      m_q.delete(); m_drop = 0; m_und = 1'b0;
    end else if (fl) begin
      m_q.delete();
    end else begin
      if (req && m_q.size() == 0) m_und = 1'b1;
      if (popok) void'(m_q.pop_front());
      if (acc && d.target_steps != 0) m_q.push_back(d);
      else if (acc && m_drop < DMAX) m_drop++;
    end
    #1;
    wr_valid = 1'b0; data_request = 1'b0; flush = 1'b0; rst = 1'b0;
    check_all();
  endtask

  initial begin
    motion_segment_t s;
    // Reset state
    cyc(0, '0, 0, 0, 1);
    cyc(0, '0, 0, 0, 1);
    chk("rst_wr_ready", 128'(wr_ready), 128'(1));
    chk("rst_avail", 128'(data_available), 128'(0));
    chk("rst_level", 128'(level), 128'(0));

    // Three pushes, then drain in order
    cyc(1, mkseg(5), 0, 0, 0);
    cyc(1, mkseg(7), 0, 0, 0);
    cyc(1, mkseg(9), 0, 0, 0);
    chk("level_3", 128'(level), 128'(3));
    chk("head_5", 128'(data.target_steps), 128'(5));
    cyc(0, '0, 1, 0, 0);
    chk("head_7", 128'(data.target_steps), 128'(7));
    cyc(0, '0, 1, 0, 0);
    chk("head_9", 128'(data.target_steps), 128'(9));
    cyc(0, '0, 1, 0, 0);
    chk("drained_avail", 128'(data_available), 128'(0));
    chk("drained_level", 128'(level), 128'(0));
    chk("drained_und", 128'(underflow_err), 128'(0));

    // Fill, blocked push, push+pop while full
    for (int i = 0; i < DEPTH; i++) cyc(1, mkseg(100 + i), 0, 0, 0);
    chk("full_ready", 128'(wr_ready), 128'(0));
    chk("full_level", 128'(level), 128'(DEPTH));
    cyc(1, mkseg(999), 0, 0, 0);
    chk("blocked_level", 128'(level), 128'(DEPTH));
    cyc(1, mkseg(998), 1, 0, 0);
    chk("full_pp_level", 128'(level), 128'(DEPTH - 1));
    chk("full_pp_ready", 128'(wr_ready), 128'(1));

    // Streaming push+pop at level 1 across pointer wrap
    cyc(0, '0, 0, 1, 0);
    cyc(1, mkseg(1), 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      s = mkseg(2 + i);
      cyc(1, s, 1, 0, 0);
      chk("stream_level", 128'(level), 128'(1));
      chk("stream_head", 128'(data), 128'(s));
    end

    // Zero-step drops and counter saturation
    cyc(0, '0, 0, 0, 1);
    cyc(1, mkseg(0), 0, 0, 0);
    cyc(1, mkseg(0), 0, 0, 0);
    cyc(1, mkseg(4), 0, 0, 0);
    chk("drop_2", 128'(drop_count), 128'(2));
    chk("drop_level", 128'(level), 128'(1));
    chk("drop_head", 128'(data.target_steps), 128'(4));
    for (int i = 0; i < DMAX + 4; i++) cyc(1, mkseg(0), 0, 0, 0);
    chk("drop_sat", 128'(drop_count), 128'(DMAX));

    // Underflow and flush with concurrent push
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 1, 0, 0);
    chk("und_set", 128'(underflow_err), 128'(1));
    chk("und_level", 128'(level), 128'(0));
    for (int i = 0; i < 5; i++) cyc(1, mkseg(50 + i), 0, 0, 0);
    chk("pre_flush_level", 128'(level), 128'(5));
    cyc(1, mkseg(77), 1, 1, 0);
    chk("flush_level", 128'(level), 128'(0));
    chk("flush_avail", 128'(data_available), 128'(0));
    chk("flush_und", 128'(underflow_err), 128'(1));
    chk("flush_drop", 128'(drop_count), 128'(DMAX));

    // Randomized traffic against the model
    cyc(0, '0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      int unsigned ts;
      ts = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 1000);
      cyc(bit'($urandom_range(0, 3) != 0), mkseg(ts), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 63) == 0), bit'($urandom_range(0, 199) == 0));
    end

    // Final reset restores reset values
    cyc(1, mkseg(3), 1, 1, 1);
    chk("final_ready", 128'(wr_ready), 128'(1));
    chk("final_avail", 128'(data_available), 128'(0));
    chk("final_level", 128'(level), 128'(0));
    chk("final_drop", 128'(drop_count), 128'(0));
    chk("final_und", 128'(underflow_err), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
